dmem_responder: RTL

- Data-memory responder for the CPU's MEM-stage load/store port: the slave end of the same byte-enable/size interface the MEM stage drives.
- Accepts one request at a time with a req/addr_ok handshake and models a fixed access latency with a countdown counter.
- Commits byte-enabled writes to an internal word array and returns full 32-bit words for reads. Byte/half extraction stays in the CPU.
- Sits between the CPU core and the SoC glue as the on-chip data RAM.

---
 rtl/dmem_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: on-chip data RAM that answers the MEM stage's load/store
// port. It accepts one request at a time, returns data_ok a fixed LATENCY
// cycles after acceptance, commits byte-enabled stores and returns whole
// words for loads.
// Optional build macro: DMEM_ERR_EN adds an err output that flags
// out-of-range, misaligned and reserved-size accesses.
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
`ifdef DMEM_ERR_EN
  output logic        err,
`endif
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic [3:0]              sel_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    err_q;
  logic                    err_d;
  logic                    resp;
  logic                    commit;

  logic [31:0] mem [DEPTH];

`ifdef DMEM_ERR_EN
  // Error classification of the incoming request, captured at accept time.
  always_comb begin
    err_d = 1'b0;
    if (addr[31:ADDR_WIDTH+2] != '0)              err_d = 1'b1;
    if (size == 2'b01 && addr[0])                 err_d = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00)      err_d = 1'b1;
    if (size == 2'b11)                            err_d = 1'b1;
  end
`else
  // Without error checking, size and the upper/lower address bits are
  // don't-cares; fold them into a sink so they are visibly intentional.
  logic unused_bits;
  assign unused_bits = ^{size, addr[1:0], addr[31:ADDR_WIDTH+2]};
  assign err_d = 1'b0;
`endif

  // The response cycle is the BUSY cycle whose countdown has reached zero;
  // an asserted reset always suppresses it.
  assign resp    = (state_q == BUSY) && (cnt_q == 4'd0) && !rst;
  assign commit  = resp && wr_q && !err_q;

  assign addr_ok = (state_q == IDLE) && req && !rst;
  assign busy    = (state_q == BUSY) && !rst;
  assign data_ok = resp;
  assign rdata   = (resp && !wr_q && !err_q) ? mem[idx_q] : 32'd0;
`ifdef DMEM_ERR_EN
  assign err     = resp && err_q;
`endif

  // Request FSM: latch the request on accept, count down the latency,
  // return to IDLE at the end of the response cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q    <= wr;
            sel_q   <= sel;
            idx_q   <= addr[ADDR_WIDTH+1:2];
            wdata_q <= wdata;
            err_q   <= err_d;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-lane store commit at the end of the response cycle; contents
  // survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
